// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus responder: FSM states, MMIO offsets,
// op encoding and the latched request payload.
package mem_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ST_W   = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  localparam logic [DATA_W-1:0] LED_OFS = 32'h0000_0000;
  localparam logic [DATA_W-1:0] CNT_OFS = 32'h0000_0004;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Request as captured at acceptance; 'both' flags a read+write collision.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              op;
    logic              both;
  } req_t;

endpackage

// File: rtl/sync_word_ram.sv
// Word RAM with synchronous write and combinational read; array is not reset.
module sync_word_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder with wait states, ready/error handshake, word RAM
// and an MMIO window holding an LED register and a free-running counter.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Mem_data,
  output logic        Mem_ready,
  output logic        Mem_err,
  output logic [7:0]  led
);

  localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned LED_W  = 8;

  logic [ST_W-1:0]   state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_err_q, mem_err_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;

  req_t              live;
  req_t              cur;
  logic              access;
  logic              fault;
  logic              is_led, is_cnt, is_ram;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // With zero wait states the access happens on the accepting edge, so decode
  // the live request in IDLE and the latched copy otherwise.
  always_comb begin
    live.addr  = Address;
    live.wdata = Write_data;
    live.op    = MemWrite ? OP_WR : OP_RD;
    live.both  = MemRead & MemWrite;
    cur        = (state_q == ST_IDLE) ? live : req_q;
  end

  always_comb begin
    is_led = (cur.addr == MMIO_BASE + LED_OFS);
    is_cnt = (cur.addr == MMIO_BASE + CNT_OFS);
    is_ram = (cur.addr[31:ADDR_WIDTH+2] == '0);
    fault  = (cur.addr[1:0] != 2'b00) | cur.both | ~(is_led | is_cnt | is_ram);
  end

  sync_word_ram #(
    .ADDR_W (ADDR_WIDTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .addr    (cur.addr[ADDR_WIDTH+1:2]),
    .wdata   (cur.wdata),
    .rdata_c (ram_rdata)
  );

  // Next-state, access and output logic.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    req_d       = req_q;
    mem_data_d  = mem_data_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    led_d       = led_q;
    cnt_d       = cnt_q + 32'd1;
    access      = 1'b0;
    ram_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          req_d = live;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (access) begin
      mem_ready_d = 1'b1;
      if (fault) begin
        mem_err_d = 1'b1;
      end else if (cur.op == OP_WR) begin
        if (is_led) begin
          led_d = cur.wdata[LED_W-1:0];
        end else if (!is_cnt) begin
          ram_we = 1'b1;
        end
      end else begin
        if (is_led) begin
          mem_data_d = {24'b0, led_q};
        end else if (is_cnt) begin
          mem_data_d = cnt_q;
        end else begin
          mem_data_d = ram_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      req_q       <= '0;
      mem_data_q  <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      led_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      req_q       <= req_d;
      mem_data_q  <= mem_data_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      led_q       <= led_d;
      cnt_q       <= cnt_d;
    end
  end

  assign Mem_data  = mem_data_q;
  assign Mem_ready = mem_ready_q;
  assign Mem_err   = mem_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) driven in turn,
// checked against a behavioural memory/LED/counter model.
module tb_mem_bus_responder;

  localparam logic [31:0] MMIO   = 32'h4000_0000;
  localparam int          K_DATA = 0;
  localparam int          K_HOLD = 1;
  localparam int          K_CNT  = 2;

  typedef struct {
    int          inst;
    int          kind;
    logic [31:0] data;
    logic        err;
    logic [7:0]  led;
    int          accept;
    bit          diff;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] mdata [2];
  logic        ready [2];
  logic        err   [2];
  logic [7:0]  led   [2];

  mem_bus_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2), .MMIO_BASE(MMIO)) u_dut_w2 (
    .clk(clk), .reset(reset), .MemRead(rd[0]), .MemWrite(wr[0]), .Address(addr[0]),
    .Write_data(wdata[0]), .Mem_data(mdata[0]), .Mem_ready(ready[0]), .Mem_err(err[0]),
    .led(led[0])
  );

  mem_bus_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0), .MMIO_BASE(MMIO)) u_dut_w0 (
    .clk(clk), .reset(reset), .MemRead(rd[1]), .MemWrite(wr[1]), .Address(addr[1]),
    .Write_data(wdata[1]), .Mem_data(mdata[1]), .Mem_ready(ready[1]), .Mem_err(err[1]),
    .led(led[1])
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was released.
  int tb_edges = 0;
  always @(posedge clk) tb_edges <= reset ? tb_edges + 1 : 0;

  // Reference model state (driver side).
  logic [31:0] ram_m [2][256];
  bit          wr_m  [2][256];
  logic [7:0]  led_m [2];
  exp_t        exp_q [$];

  int checks = 0;
  int errors = 0;

  function automatic int w_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: reset checks, response checks and a latency watchdog.
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  logic [31:0] last_cnt_act = 32'h0;
  int          last_cnt_edge = 0;

  always begin
    @(negedge clk or negedge reset);
    if (!reset) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("rst_ready", 32'(ready[i]), 32'h0);
        chk("rst_err",   32'(err[i]),   32'h0);
        chk("rst_data",  mdata[i],      32'h0);
        chk("rst_led",   32'(led[i]),   32'h0);
        last_rd[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ready[i] === 1'b1) begin
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready inst=%0d act=1 exp=0 t=%0t", i, $time);
          end else begin
            exp_t e;
            logic [31:0] ed;
            e = exp_q.pop_front();
            chk("latency", 32'(tb_edges), 32'(e.accept + w_of(i)));
            chk("mem_err", 32'(err[i]), 32'(e.err));
            case (e.kind)
              K_DATA:  ed = e.data;
              K_CNT:   ed = 32'(tb_edges - 1);
              default: ed = last_rd[i];
            endcase
            chk("mem_data", mdata[i], ed);
            chk("led", 32'(led[i]), 32'(e.led));
            if (e.kind == K_CNT) begin
              if (e.diff) begin
                chk("cnt_diff", mdata[i] - last_cnt_act, 32'(tb_edges - last_cnt_edge));
              end
              last_cnt_act  = mdata[i];
              last_cnt_edge = tb_edges;
            end
            if (e.kind != K_HOLD) last_rd[i] = ed;
          end
        end
      end
      if (exp_q.size() > 0 && tb_edges > exp_q[0].accept + w_of(exp_q[0].inst) + 3) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout inst=%0d act=none exp=edge%0d", exp_q[0].inst,
                 exp_q[0].accept + w_of(exp_q[0].inst));
        void'(exp_q.pop_front());
      end
    end
  end

  // Issue one request, record its expected response from the model, hold it
  // until Mem_ready and drop it in the response cycle.
  task automatic txn(input int i, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit diff);
    exp_t e;
    bit   is_led, is_cnt, is_ram;
    @(negedge clk);
    is_led = (a == MMIO);
    is_cnt = (a == MMIO + 32'd4);
    is_ram = (a < 32'd1024);
    e.inst   = i;
    e.kind   = K_HOLD;
    e.data   = 32'h0;
    e.diff   = diff;
    e.err    = (a[1:0] != 2'b00) || (r && w) || !(is_led || is_cnt || is_ram);
    if (!e.err) begin
      if (w) begin
        if (is_led) led_m[i] = d[7:0];
        else if (is_ram) begin
          ram_m[i][a[9:2]] = d;
          wr_m[i][a[9:2]]  = 1'b1;
        end
      end else begin
        if (is_led) begin
          e.kind = K_DATA;
          e.data = {24'h0, led_m[i]};
        end else if (is_cnt) begin
          e.kind = K_CNT;
        end else begin
          e.kind = K_DATA;
          e.data = ram_m[i][a[9:2]];
        end
      end
    end
    e.led    = led_m[i];
    e.accept = tb_edges + 1;
    exp_q.push_back(e);
    rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready[i] === 1'b1) break;
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic rand_txn(input int i);
    int          sel;
    int          idx;
    logic [31:0] d;
    sel = int'($urandom_range(0, 8));
    idx = int'($urandom_range(0, 255));
    d   = $urandom;
    case (sel)
      0, 1: txn(i, 0, 1, 32'(idx) << 2, d, 0);
      2, 3: if (wr_m[i][idx]) txn(i, 1, 0, 32'(idx) << 2, d, 0);
            else              txn(i, 0, 1, 32'(idx) << 2, d, 0);
      4:    txn(i, 0, 1, MMIO, d, 0);
      5:    txn(i, 1, 0, MMIO, d, 0);
      6:    if (d[0]) txn(i, 1, 0, MMIO + 32'd4, d, 0);
            else      txn(i, 0, 1, MMIO + 32'd4, d, 0);
      7:    txn(i, d[1], !d[1], (32'(idx) << 2) | 32'($urandom_range(1, 3)), d, 0);
      default:
            if (d[2]) txn(i, 1, 1, 32'(idx) << 2, d, 0);
            else      txn(i, d[1], !d[1], 32'h400 + (32'($urandom_range(0, 4000)) << 2), d, 0);
    endcase
  endtask

  initial begin
    int gap;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
      led_m[i] = 8'h0;
      for (int j = 0; j < 256; j++) begin
        ram_m[i][j] = 32'h0;
        wr_m[i][j]  = 1'b0;
      end
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Zero wait states: write then read word 0.
    txn(1, 0, 1, 32'h0, 32'h1234_5678, 0);
    txn(1, 1, 0, 32'h0, 32'h0, 0);

    // Two wait states: RAM, LED and counter accesses.
    txn(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 0);
    txn(0, 0, 1, MMIO, 32'h0000_01A5, 0);
    txn(0, 1, 0, MMIO, 32'h0, 0);
    txn(0, 1, 0, MMIO + 32'd4, 32'h0, 0);
    txn(0, 0, 1, MMIO + 32'd4, 32'h5, 0);
    txn(0, 1, 0, MMIO + 32'd4, 32'h0, 1);

    // Faulted accesses leave RAM and LED untouched.
    txn(0, 1, 0, 32'h13, 32'h0, 0);
    txn(0, 1, 0, 32'h400, 32'h0, 0);
    txn(0, 1, 1, 32'h10, 32'h0BAD_0BAD, 0);
    txn(0, 0, 1, 32'h12, 32'h0BAD_0BAD, 0);
    txn(0, 1, 0, 32'h10, 32'h0, 0);
    txn(0, 1, 0, MMIO, 32'h0, 0);

    // Counter reads a random distance apart.
    txn(0, 1, 0, MMIO + 32'd4, 32'h0, 0);
    repeat ($urandom_range(3, 20)) @(negedge clk);
    txn(0, 1, 0, MMIO + 32'd4, 32'h0, 1);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 80; n++) begin
        gap = int'($urandom_range(0, 2));
        repeat (gap) @(negedge clk);
        rand_txn(i);
      end
    end

    // Reset during WAIT abandons a pending write.
    txn(0, 0, 1, 32'h20, 32'hCAFE_F00D, 0);
    txn(0, 0, 1, MMIO, 32'h0000_003C, 0);
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1111_2222;
    @(posedge clk);
    #2 reset = 1'b0;
    wr[0] = 1'b0;
    led_m[0] = 8'h0;
    led_m[1] = 8'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(0, 1, 0, 32'h20, 32'h0, 0);
    txn(0, 1, 0, MMIO, 32'h0, 0);
    txn(0, 1, 0, MMIO + 32'd4, 32'h0, 0);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the multicycle CPU's memory port (MemRead/MemWrite/Address/Write_data in, Mem_data out).
- Adds a ready/error handshake and a programmable wait-state count, so the CPU controller can be exercised against slow memory.
- Serves a word-addressed RAM plus a small MMIO window: an LED register and a free-running cycle counter.
- Sits between the CPU top level and the memory; it replaces direct instantiation of the single-cycle memory.

Parameters:
- ADDR_WIDTH, 8, word-index bits of the RAM (2^ADDR_WIDTH words, byte range 0 .. 4*2^ADDR_WIDTH-1).
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; 0 is legal.
- MMIO_BASE, 32'h4000_0000, byte base of the MMIO window (LED at +0, counter at +4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  read request, level; held until Mem_ready is seen.
- MemWrite  in  1  write request, level; held until Mem_ready is seen.
- Address  in  32  byte address; must be word aligned.
- Write_data  in  32  store data.
- Mem_data  out  32  read data; valid while Mem_ready=1; holds the last read value otherwise.
- Mem_ready  out  1  single-cycle response strobe.
- Mem_err  out  1  qualifies Mem_ready; access was rejected.
- led  out  8  LED register contents.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; Mem_data=0, Mem_ready=0, Mem_err=0, led=0, cycle counter=0.
  - RAM contents are not cleared.
  - A reset mid-operation abandons the transaction; a pending write is never performed.
- Cycle counter: 32-bit, increments every cycle out of reset, wraps 32'hFFFF_FFFF -> 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If MemRead or MemWrite is sampled high, latch Address, Write_data and the op.
  - Go to WAIT with wcnt=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: decrement wcnt; at wcnt=0 perform the access on that edge and go to RESP.
- Access rules:
  - Read updates Mem_data.
  - Write updates RAM or LED on the access edge.
  - A faulted access performs no write, leaves Mem_data unchanged and sets Mem_err.
- RESP:
  - Mem_ready=1 for exactly one cycle, with Mem_err valid in the same cycle.
  - Always returns to IDLE. Mem_err clears with Mem_ready.
- Latency: Mem_ready is high in the (WAIT_CYCLES+1)th cycle after the accepting edge.
- Request timing: the requester must drop or replace its request on the edge that ends RESP. Anything high in IDLE afterwards is a new request; back-to-back requests therefore cost one idle cycle minimum.
- Requests outside IDLE are ignored; the latched copy is used.
- Error cases (Mem_err=1):
  - Address[1:0] != 0.
  - MemRead and MemWrite both high at acceptance.
  - Address outside both the RAM range and the MMIO window (base+0, base+4).
- MMIO:
  - Read at +0 returns {24'b0, led}; write at +0 loads led = Write_data[7:0].
  - Read at +4 returns the counter value at the access edge.
  - Write at +4 is ignored, with no error.
- RAM index = Address[ADDR_WIDTH+1:2]. The RAM is synchronous-write; its read is combinational but sampled only on the access edge.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum (IDLE, WAIT, RESP).
  - MMIO offset constants (LED_OFS=0, CNT_OFS=4).
  - Op encoding (OP_RD, OP_WR).
- One sub-module, sync_word_ram:
  - Parameterised depth.
  - Write-enable port; combinational read.
  - No reset on the array.

Test Plan:
- WAIT_CYCLES=2: write 32'hDEADBEEF to 0x10, then read 0x10. Each Mem_ready arrives exactly 3 cycles after acceptance; the read returns 32'hDEADBEEF with Mem_err=0.
- WAIT_CYCLES=0: read of 0x0 after the earlier write of 32'h1234_5678 there. Mem_ready is high in the first cycle after acceptance, with Mem_data=32'h1234_5678.
- Write 32'h0000_01A5 to 0x4000_0000. led becomes 8'hA5; a read there returns 32'h0000_00A5. A write of 32'h5 to 0x4000_0004 leaves the counter unaffected, with Mem_err=0.
- Each of the following gives Mem_ready with Mem_err=1 and no state change (prior RAM and led values intact):
  - Read of 0x13 (misaligned).
  - Read of 0x0000_0400 with ADDR_WIDTH=8 (out of range).
  - MemRead=MemWrite=1.
- Assert a write to 0x20, then pull reset low during WAIT. Mem_ready=0 and led=0 immediately (asynchronously); after release, a read of 0x20 returns the old value.
- Read 0x4000_0004 twice, N cycles apart. The returned values differ by exactly N.
